// File: rtl/game_session_ctrl.sv
// Game-session controller: login handoff, play gating, level/score/lives, logout lockout.
// Optional pause support is compiled in when GSC_PAUSE_EN is defined.
module game_session_ctrl #(
    parameter int MAX_LEVEL  = 5,
    parameter int LEVEL_W    = 4,
    parameter int SCORE_W    = 7,
    parameter int LEVEL_STEP = 1,
    parameter int LIVES      = 1,
    parameter int DELAY_CYC  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               passed,
    input  logic               correct,
    input  logic               incorrect,
    input  logic               game_b,
    input  logic               psub_b_in,
    input  logic               seq_b_in,
    input  logic               timeout,
    output logic               ts_enable,
    output logic               ts_reconfig,
    output logic               psub_b_out,
    output logic               seq_b_out,
    output logic               dead,
    output logic               life_lost,
    output logic               checkscore,
    output logic               logout,
    output logic               paused,
    output logic [LEVEL_W-1:0] current_level,
    output logic [SCORE_W-1:0] player_score,
    output logic [2:0]         lives_left
);

    localparam int STEP_W = $clog2(LEVEL_STEP + 1);
    localparam int CNT_W  = $clog2(DELAY_CYC + 1);

    typedef enum logic [2:0] {
        INACTIVE   = 3'd0,
        RECONFIG   = 3'd1,
        WAIT_START = 3'd2,
        PLAY       = 3'd3,
`ifdef GSC_PAUSE_EN
        PAUSE      = 3'd4,
`endif
        GAMEOVER   = 3'd5,
        DELAY      = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic               ts_enable_q, ts_enable_d;
    logic               ts_reconfig_q, ts_reconfig_d;
    logic               psub_q, psub_d;
    logic               seq_q, seq_d;
    logic               dead_q, dead_d;
    logic               life_lost_q, life_lost_d;
    logic               checkscore_q, checkscore_d;
    logic               logout_q, logout_d;
    logic               paused_q, paused_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        score_d       = score_q;
        lives_d       = lives_q;
        step_d        = step_q;
        cnt_d         = cnt_q;
        ts_reconfig_d = 1'b0;
        dead_d        = 1'b0;
        life_lost_d   = 1'b0;
        checkscore_d  = 1'b0;
        logout_d      = 1'b0;

        unique case (state_q)
            INACTIVE: begin
                if (passed) state_d = RECONFIG;
            end
            RECONFIG: begin
                ts_reconfig_d = 1'b1;
                level_d       = '0;
                score_d       = '0;
                lives_d       = 3'(LIVES);
                step_d        = '0;
                state_d       = WAIT_START;
            end
            WAIT_START: begin
                if (game_b) begin
                    state_d = PLAY;
                    level_d = LEVEL_W'(1);
                end else if (psub_b_in) begin
                    state_d  = DELAY;
                    logout_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            PLAY: begin
                if (timeout) begin
                    state_d      = GAMEOVER;
                    checkscore_d = 1'b1;
                end else if (incorrect) begin
                    if (lives_q > 3'd1) begin
                        lives_d     = lives_q - 3'd1;
                        life_lost_d = 1'b1;
                    end else begin
                        lives_d      = '0;
                        dead_d       = 1'b1;
                        checkscore_d = 1'b1;
                        state_d      = GAMEOVER;
                    end
                end else if (correct) begin
                    if (!(&score_q)) score_d = score_q + SCORE_W'(1);
                    if (step_q + STEP_W'(1) == STEP_W'(LEVEL_STEP)) begin
                        step_d = '0;
                        if (level_q != LEVEL_W'(MAX_LEVEL))
                            level_d = level_q + LEVEL_W'(1);
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
`ifdef GSC_PAUSE_EN
                else if (game_b) begin
                    state_d = PAUSE;
                end
`endif
            end
`ifdef GSC_PAUSE_EN
            PAUSE: begin
                if (game_b) begin
                    state_d = PLAY;
                end else if (psub_b_in) begin
                    state_d  = DELAY;
                    logout_d = 1'b1;
                    cnt_d    = '0;
                end
            end
`endif
            GAMEOVER: begin
                if (game_b) begin
                    state_d = RECONFIG;
                end else if (psub_b_in) begin
                    state_d  = DELAY;
                    logout_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            DELAY: begin
                if (cnt_q == CNT_W'(DELAY_CYC - 1)) state_d = INACTIVE;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = INACTIVE;
        endcase

        // Buttons pass only while play continues through this edge
        psub_d      = (state_q == PLAY) && (state_d == PLAY) && psub_b_in;
        seq_d       = (state_q == PLAY) && (state_d == PLAY) && seq_b_in;
        ts_enable_d = (state_d == PLAY);
`ifdef GSC_PAUSE_EN
        paused_d    = (state_d == PAUSE);
`else
        paused_d    = 1'b0;
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= INACTIVE;
            ts_enable_q   <= 1'b0;
            ts_reconfig_q <= 1'b0;
            psub_q        <= 1'b0;
            seq_q         <= 1'b0;
            dead_q        <= 1'b0;
            life_lost_q   <= 1'b0;
            checkscore_q  <= 1'b0;
            logout_q      <= 1'b0;
            paused_q      <= 1'b0;
            level_q       <= '0;
            score_q       <= '0;
            lives_q       <= '0;
            step_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            ts_enable_q   <= ts_enable_d;
            ts_reconfig_q <= ts_reconfig_d;
            psub_q        <= psub_d;
            seq_q         <= seq_d;
            dead_q        <= dead_d;
            life_lost_q   <= life_lost_d;
            checkscore_q  <= checkscore_d;
            logout_q      <= logout_d;
            paused_q      <= paused_d;
            level_q       <= level_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            step_q        <= step_d;
            cnt_q         <= cnt_d;
        end
    end

    assign ts_enable     = ts_enable_q;
    assign ts_reconfig   = ts_reconfig_q;
    assign psub_b_out    = psub_q;
    assign seq_b_out     = seq_q;
    assign dead          = dead_q;
    assign life_lost     = life_lost_q;
    assign checkscore    = checkscore_q;
    assign logout        = logout_q;
    assign paused        = paused_q;
    assign current_level = level_q;
    assign player_score  = score_q;
    assign lives_left    = lives_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl: two instances differing only in score width.
// Expected values are hand-derived from the cycle behaviour of the controller.
module tb_game_session_ctrl;

    logic clk = 1'b0;
    logic rst, passed, correct, incorrect, game_b, psub_b_in, seq_b_in, timeout;

    logic       a_ts_enable, a_ts_reconfig, a_psub_out, a_seq_out;
    logic       a_dead, a_life_lost, a_checkscore, a_logout, a_paused;
    logic [3:0] a_level;
    logic [6:0] a_score;
    logic [2:0] a_lives;

    logic       b_ts_enable, b_ts_reconfig, b_psub_out, b_seq_out;
    logic       b_dead, b_life_lost, b_checkscore, b_logout, b_paused;
    logic [3:0] b_level;
    logic [2:0] b_score;
    logic [2:0] b_lives;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_session_ctrl #(
        .MAX_LEVEL(5), .LEVEL_W(4), .SCORE_W(7),
        .LEVEL_STEP(2), .LIVES(3), .DELAY_CYC(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .passed(passed), .correct(correct),
        .incorrect(incorrect), .game_b(game_b), .psub_b_in(psub_b_in),
        .seq_b_in(seq_b_in), .timeout(timeout),
        .ts_enable(a_ts_enable), .ts_reconfig(a_ts_reconfig),
        .psub_b_out(a_psub_out), .seq_b_out(a_seq_out),
        .dead(a_dead), .life_lost(a_life_lost), .checkscore(a_checkscore),
        .logout(a_logout), .paused(a_paused), .current_level(a_level),
        .player_score(a_score), .lives_left(a_lives)
    );

    game_session_ctrl #(
        .MAX_LEVEL(5), .LEVEL_W(4), .SCORE_W(3),
        .LEVEL_STEP(2), .LIVES(3), .DELAY_CYC(16)
    ) u_dut_b (
        .clk(clk), .rst(rst), .passed(passed), .correct(correct),
        .incorrect(incorrect), .game_b(game_b), .psub_b_in(psub_b_in),
        .seq_b_in(seq_b_in), .timeout(timeout),
        .ts_enable(b_ts_enable), .ts_reconfig(b_ts_reconfig),
        .psub_b_out(b_psub_out), .seq_b_out(b_seq_out),
        .dead(b_dead), .life_lost(b_life_lost), .checkscore(b_checkscore),
        .logout(b_logout), .paused(b_paused), .current_level(b_level),
        .player_score(b_score), .lives_left(b_lives)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; passed = 1'b0; correct = 1'b0; incorrect = 1'b0;
        game_b = 1'b0; psub_b_in = 1'b0; seq_b_in = 1'b0; timeout = 1'b0;
        tick(); tick();
        check("rst_ts_enable", a_ts_enable, 0);
        check("rst_ts_reconfig", a_ts_reconfig, 0);
        check("rst_level", a_level, 0);
        check("rst_score", a_score, 0);
        check("rst_lives", a_lives, 0);
        check("rst_logout", a_logout, 0);
        check("rst_paused", a_paused, 0);
        rst = 1'b0;

        // login: reconfig pulse two edges after passed
        passed = 1'b1; tick(); passed = 1'b0;
        check("reconfig_lat1", a_ts_reconfig, 0);
        tick();
        check("reconfig_hi", a_ts_reconfig, 1);
        check("reconfig_lives", a_lives, 3);
        check("reconfig_level", a_level, 0);
        tick();
        check("reconfig_lo", a_ts_reconfig, 0);
        check("wait_ts_enable", a_ts_enable, 0);

        // start game
        game_b = 1'b1; tick(); game_b = 1'b0;
        check("start_ts_enable", a_ts_enable, 1);
        check("start_level", a_level, 1);

        // button forwarding with one-cycle latency
        psub_b_in = 1'b1; tick(); psub_b_in = 1'b0;
        check("fwd_psub", a_psub_out, 1);
        seq_b_in = 1'b1; tick(); seq_b_in = 1'b0;
        check("fwd_psub_clr", a_psub_out, 0);
        check("fwd_seq", a_seq_out, 1);
        tick();
        check("fwd_seq_clr", a_seq_out, 0);

        // eleven corrects: level +1 every 2, saturating at 5; B score sat at 7
        for (int i = 1; i <= 11; i++) begin
            correct = 1'b1; tick();
            check("corr_score_a", a_score, i);
            check("corr_score_b", b_score, (i > 7) ? 7 : i);
            check("corr_level", a_level, (1 + i / 2 > 5) ? 5 : 1 + i / 2);
            check("corr_checkscore", a_checkscore, 0);
        end
        correct = 1'b0;

`ifdef GSC_PAUSE_EN
        game_b = 1'b1; tick(); game_b = 1'b0;
        check("pause_paused", a_paused, 1);
        check("pause_ts_enable", a_ts_enable, 0);
        correct = 1'b1; seq_b_in = 1'b1; tick();
        correct = 1'b0; seq_b_in = 1'b0;
        check("pause_score", a_score, 11);
        check("pause_seq_block", a_seq_out, 0);
        game_b = 1'b1; tick(); game_b = 1'b0;
        check("resume_paused", a_paused, 0);
        check("resume_ts_enable", a_ts_enable, 1);
        check("resume_score", a_score, 11);
`else
        game_b = 1'b1; tick(); game_b = 1'b0;
        check("nopause_paused", a_paused, 0);
        check("nopause_ts_enable", a_ts_enable, 1);
        check("nopause_level", a_level, 5);
`endif

        // two non-final lives lost
        for (int k = 1; k <= 2; k++) begin
            incorrect = 1'b1; tick(); incorrect = 1'b0;
            check("inc_life_lost", a_life_lost, 1);
            check("inc_lives", a_lives, 3 - k);
            check("inc_dead", a_dead, 0);
            check("inc_score", a_score, 11);
            check("inc_ts_enable", a_ts_enable, 1);
            tick();
            check("inc_life_lost_clr", a_life_lost, 0);
        end

        // timeout beats incorrect; exit-cycle button not forwarded
        timeout = 1'b1; incorrect = 1'b1; seq_b_in = 1'b1; tick();
        timeout = 1'b0; incorrect = 1'b0; seq_b_in = 1'b0;
        check("to_checkscore", a_checkscore, 1);
        check("to_dead", a_dead, 0);
        check("to_ts_enable", a_ts_enable, 0);
        check("to_lives", a_lives, 1);
        check("to_score_a", a_score, 11);
        check("to_score_b", b_score, 7);
        check("to_seq_block", a_seq_out, 0);
        tick();
        check("to_checkscore_clr", a_checkscore, 0);
        check("go_score_held", a_score, 11);

        // new game from GAMEOVER
        game_b = 1'b1; tick(); game_b = 1'b0;
        tick();
        check("g2_reconfig", a_ts_reconfig, 1);
        check("g2_score", a_score, 0);
        check("g2_lives", a_lives, 3);
        game_b = 1'b1; tick(); game_b = 1'b0;
        check("g2_ts_enable", a_ts_enable, 1);

        // three incorrects: two life_lost then dead
        for (int k = 1; k <= 3; k++) begin
            incorrect = 1'b1; tick(); incorrect = 1'b0;
            check("g2_lives_k", a_lives, 3 - k);
            check("g2_life_lost", a_life_lost, (k < 3) ? 1 : 0);
            check("g2_dead", a_dead, (k == 3) ? 1 : 0);
            check("g2_checkscore", a_checkscore, (k == 3) ? 1 : 0);
            check("g2_ts_enable_k", a_ts_enable, (k < 3) ? 1 : 0);
            tick();
            check("g2_dead_clr", a_dead, 0);
            check("g2_life_lost_clr", a_life_lost, 0);
        end

        // logout and lockout, passed held throughout
        psub_b_in = 1'b1; tick(); psub_b_in = 1'b0;
        check("lo_logout", a_logout, 1);
        passed = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            tick();
            check("lock_reconfig", a_ts_reconfig, 0);
            check("lock_logout", a_logout, 0);
        end
        tick();
        check("lock_end_reconfig", a_ts_reconfig, 1);
        passed = 1'b0;

        // logout from WAIT_START
        psub_b_in = 1'b1; tick(); psub_b_in = 1'b0;
        check("ws_logout", a_logout, 1);
        check("ws_ts_enable", a_ts_enable, 0);

        // reset mid-game overrides a timeout
        rst = 1'b1; tick(); rst = 1'b0;
        passed = 1'b1; tick(); passed = 1'b0;
        tick();
        game_b = 1'b1; tick(); game_b = 1'b0;
        check("mid_ts_enable", a_ts_enable, 1);
        rst = 1'b1; timeout = 1'b1; tick(); rst = 1'b0; timeout = 1'b0;
        check("mid_checkscore", a_checkscore, 0);
        check("mid_ts_enable_clr", a_ts_enable, 0);
        check("mid_level", a_level, 0);
        check("mid_lives", a_lives, 0);
        check("mid_logout", a_logout, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
